// File: rtl/hamming_pkg.sv
// Shared types and helpers for the Hamming-cost / winner-take-all engine.
//   cost_w    : bit width of a Hamming cost for a given descriptor width
//   nodes_at  : operand count at a given adder-tree level
//   pop_count : the pop-count LUT contents, one entry per LUT input pattern
package hamming_pkg;

  localparam int unsigned COORD_W_DEF = 16;

  typedef logic [COORD_W_DEF-1:0] coords_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } wta_state_e;

  function automatic int unsigned cost_w(int unsigned blk);
    return $clog2(blk + 1);
  endfunction

  // Operands remaining after lvl pairwise reductions (odd ones pass through).
  function automatic int unsigned nodes_at(int unsigned n, int unsigned lvl);
    int unsigned r;
    r = n;
    for (int unsigned i = 0; i < lvl; i++) r = (r + 1) / 2;
    return r;
  endfunction

  // Number of set bits among the low n bits (n <= 32).
  function automatic int unsigned pop_count(logic [31:0] bits, int unsigned n);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n) cnt = cnt + {31'b0, bits[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/hamming_cost_wta_if.sv
// Candidate-stream and result bus of hamming_cost_wta.
//   master : drives candidate beats (in_*, left, right), observes results
//   slave  : the engine; consumes beats, drives cost_* / best_* / seq_err
interface hamming_cost_wta_if
  import hamming_pkg::*;
#(
  parameter int unsigned BLK_SIZE = 256,
  parameter int unsigned COORD_W  = 16,
  parameter int unsigned IDX_W    = 16,
  parameter int unsigned CNT_W    = 8
) ();

  localparam int unsigned COST_W = cost_w(BLK_SIZE);

  logic                in_valid;
  logic                in_first;
  logic                in_last;
  logic [BLK_SIZE-1:0] left;
  logic [BLK_SIZE-1:0] right;
  logic [COORD_W-1:0]  in_coords;
  logic [IDX_W-1:0]    in_index;

  logic                cost_valid;
  logic [COST_W-1:0]   cost;
  logic [IDX_W-1:0]    cost_index;
  logic                best_valid;
  logic [IDX_W-1:0]    best_index;
  logic [COST_W-1:0]   best_cost;
  logic [COST_W-1:0]   second_cost;
  logic [COORD_W-1:0]  best_coords;
  logic [CNT_W-1:0]    best_count;
  logic                seq_err;

  modport master (
    output in_valid, in_first, in_last, left, right, in_coords, in_index,
    input  cost_valid, cost, cost_index, best_valid, best_index, best_cost,
           second_cost, best_coords, best_count, seq_err
  );

  modport slave (
    input  in_valid, in_first, in_last, left, right, in_coords, in_index,
    output cost_valid, cost, cost_index, best_valid, best_index, best_cost,
           second_cost, best_coords, best_count, seq_err
  );

endinterface

// File: rtl/hamming_cost_wta_popcount_tree.sv
// Registered pop-count: LUT stage followed by a pairwise adder tree with one
// register per level, plus a valid/sideband delay line of matching depth.
//   clk, reset : clock, synchronous active-high reset
//   in_valid   : in_bits / in_sb are valid this cycle
//   in_bits    : vector to count
//   in_sb      : sideband carried alongside the count
//   out_valid  : out_pop / out_sb valid (1 + tree-level cycles after in_valid)
//   out_pop    : number of set bits in in_bits
//   out_sb     : sideband matching out_pop
// Every pipeline register loads only when its input stage is valid, so the
// outputs hold their last value between valid beats.
module popcount_tree
  import hamming_pkg::*;
#(
  parameter int unsigned BLK_SIZE = 256,
  parameter int unsigned LUT_BITS = 4,
  parameter int unsigned SB_W     = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [BLK_SIZE-1:0]         in_bits,
  input  logic [SB_W-1:0]             in_sb,
  output logic                        out_valid,
  output logic [cost_w(BLK_SIZE)-1:0] out_pop,
  output logic [SB_W-1:0]             out_sb
);

  localparam int unsigned NUM_LUTS  = BLK_SIZE / LUT_BITS;
  localparam int unsigned PW        = $clog2(LUT_BITS + 1);
  localparam int unsigned TREE_LVLS = $clog2(NUM_LUTS);
  localparam int unsigned DEPTH     = 1 + TREE_LVLS;
  localparam int unsigned COST_W    = cost_w(BLK_SIZE);
  localparam int unsigned ROOT_W    = PW + TREE_LVLS;

  logic [DEPTH-1:0] vld_d, vld_q;
  logic [SB_W-1:0]  sb_d [DEPTH];
  logic [SB_W-1:0]  sb_q [DEPTH];
  logic [PW-1:0]    lut_d [NUM_LUTS];
  logic [PW-1:0]    lut_q [NUM_LUTS];
  logic [ROOT_W-1:0] root;

  // Valid and sideband delay line; stage s mirrors the data register at level s.
  always_comb begin
    vld_d[0] = in_valid;
    sb_d[0]  = in_valid ? in_sb : sb_q[0];
    for (int unsigned s = 1; s < DEPTH; s++) begin
      vld_d[s] = vld_q[s-1];
      sb_d[s]  = vld_q[s-1] ? sb_q[s-1] : sb_q[s];
    end
  end

  // LUT stage: one pop-count per LUT_BITS slice.
  always_comb begin
    for (int unsigned i = 0; i < NUM_LUTS; i++) begin
      lut_d[i] = in_valid
               ? PW'(pop_count(32'(in_bits[i*LUT_BITS +: LUT_BITS]), LUT_BITS))
               : lut_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned s = 0; s < DEPTH; s++) sb_q[s] <= '0;
      for (int unsigned i = 0; i < NUM_LUTS; i++) lut_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int unsigned s = 0; s < DEPTH; s++) sb_q[s] <= sb_d[s];
      for (int unsigned i = 0; i < NUM_LUTS; i++) lut_q[i] <= lut_d[i];
    end
  end

  // Adder tree: level k holds sums one bit wider than level k-1.
  for (genvar k = 1; k <= TREE_LVLS; k++) begin : g_lvl
    localparam int unsigned N_IN  = nodes_at(NUM_LUTS, k - 1);
    localparam int unsigned N_OUT = nodes_at(NUM_LUTS, k);
    localparam int unsigned W     = PW + k;

    logic [W-2:0] src   [N_IN];
    logic [W-1:0] sum_d [N_OUT];
    logic [W-1:0] sum_q [N_OUT];

    if (k == 1) begin : g_src_lut
      assign src = lut_q;
    end else begin : g_src_lvl
      assign src = g_lvl[k-1].sum_q;
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_node
      if (2 * j + 1 < N_IN) begin : g_pair
        assign sum_d[j] = vld_q[k-1] ? (W'(src[2*j]) + W'(src[2*j+1])) : sum_q[j];
      end else begin : g_pass
        assign sum_d[j] = vld_q[k-1] ? W'(src[2*j]) : sum_q[j];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned j = 0; j < N_OUT; j++) sum_q[j] <= '0;
      end else begin
        for (int unsigned j = 0; j < N_OUT; j++) sum_q[j] <= sum_d[j];
      end
    end
  end

  if (TREE_LVLS == 0) begin : g_root_lut
    assign root = lut_q[0];
  end else begin : g_root_tree
    assign root = g_lvl[TREE_LVLS].sum_q[0];
  end

  // The root can never exceed BLK_SIZE, so the truncation is lossless.
  assign out_pop   = COST_W'(root);
  assign out_valid = vld_q[DEPTH-1];
  assign out_sb    = sb_q[DEPTH-1];

endmodule

// File: rtl/hamming_cost_wta.sv
// Hamming-cost engine with a streaming winner-take-all stage for census
// stereo matching. Per candidate beat it emits the pipelined Hamming cost;
// per framed group it reports the lowest-cost index, its cost, the runner-up
// cost, the group coordinates and the candidate count.
//   clk, reset : clock, synchronous active-high reset
//   bus        : candidate stream in (in_*, left, right) and results out
//                (cost_*, best_*, seq_err); see hamming_cost_wta_if
module hamming_cost_wta
  import hamming_pkg::*;
#(
  parameter int unsigned BLK_SIZE = 256,
  parameter int unsigned LUT_BITS = 4,
  parameter int unsigned COORD_W  = 16,
  parameter int unsigned IDX_W    = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  hamming_cost_wta_if.slave bus
);

  localparam int unsigned COST_W = cost_w(BLK_SIZE);
  localparam int unsigned SB_W   = 2 + IDX_W + COORD_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // XOR stage
  logic [BLK_SIZE-1:0] x_d, x_q;
  logic                xv_d, xv_q;
  logic [SB_W-1:0]     xsb_d, xsb_q;

  // Pop-count tree output
  logic                t_valid;
  logic [COST_W-1:0]   t_cost;
  logic [SB_W-1:0]     t_sb;
  logic                t_first, t_last;
  logic [IDX_W-1:0]    t_index;
  logic [COORD_W-1:0]  t_coords;

  // Running group state
  wta_state_e          state_d, state_q;
  logic [IDX_W-1:0]    run_idx_d, run_idx_q;
  logic [COST_W-1:0]   run_best_d, run_best_q;
  logic [COST_W-1:0]   run_second_d, run_second_q;
  logic [CNT_W-1:0]    run_cnt_d, run_cnt_q;
  logic [COORD_W-1:0]  run_coords_d, run_coords_q;

  // Result registers
  logic                best_valid_d, best_valid_q;
  logic [IDX_W-1:0]    best_index_d, best_index_q;
  logic [COST_W-1:0]   best_cost_d, best_cost_q;
  logic [COST_W-1:0]   second_cost_d, second_cost_q;
  logic [COORD_W-1:0]  best_coords_d, best_coords_q;
  logic [CNT_W-1:0]    best_count_d, best_count_q;
  logic                seq_err_d, seq_err_q;

  // Stage X: difference bits plus sideband, loaded only on valid beats.
  always_comb begin
    xv_d  = bus.in_valid;
    x_d   = bus.in_valid ? (bus.left ^ bus.right) : x_q;
    xsb_d = bus.in_valid ? {bus.in_first, bus.in_last, bus.in_index, bus.in_coords}
                         : xsb_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xv_q  <= 1'b0;
      x_q   <= '0;
      xsb_q <= '0;
    end else begin
      xv_q  <= xv_d;
      x_q   <= x_d;
      xsb_q <= xsb_d;
    end
  end

  popcount_tree #(
    .BLK_SIZE (BLK_SIZE),
    .LUT_BITS (LUT_BITS),
    .SB_W     (SB_W)
  ) u_tree (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (xv_q),
    .in_bits   (x_q),
    .in_sb     (xsb_q),
    .out_valid (t_valid),
    .out_pop   (t_cost),
    .out_sb    (t_sb)
  );

  assign t_first  = t_sb[SB_W-1];
  assign t_last   = t_sb[SB_W-2];
  assign t_index  = t_sb[COORD_W +: IDX_W];
  assign t_coords = t_sb[COORD_W-1:0];

  // WTA next state. A first beat always opens a fresh group (abandoning any
  // open one); strict '<' keeps the earlier candidate on ties.
  always_comb begin
    state_d       = state_q;
    run_idx_d     = run_idx_q;
    run_best_d    = run_best_q;
    run_second_d  = run_second_q;
    run_cnt_d     = run_cnt_q;
    run_coords_d  = run_coords_q;
    best_valid_d  = 1'b0;
    best_index_d  = best_index_q;
    best_cost_d   = best_cost_q;
    second_cost_d = second_cost_q;
    best_coords_d = best_coords_q;
    best_count_d  = best_count_q;
    seq_err_d     = 1'b0;

    if (t_valid) begin
      if (t_first) begin
        seq_err_d    = (state_q == ACTIVE);
        state_d      = ACTIVE;
        run_idx_d    = t_index;
        run_best_d   = t_cost;
        run_second_d = '1;
        run_cnt_d    = CNT_W'(1);
        run_coords_d = t_coords;
      end else if (state_q == IDLE) begin
        seq_err_d = 1'b1;
      end else begin
        if (t_cost < run_best_q) begin
          run_second_d = run_best_q;
          run_best_d   = t_cost;
          run_idx_d    = t_index;
        end else if (t_cost < run_second_q) begin
          run_second_d = t_cost;
        end
        if (run_cnt_q != CNT_MAX) run_cnt_d = run_cnt_q + CNT_W'(1);
      end

      if (t_last && (t_first || (state_q == ACTIVE))) begin
        state_d       = IDLE;
        best_valid_d  = 1'b1;
        best_index_d  = run_idx_d;
        best_cost_d   = run_best_d;
        second_cost_d = run_second_d;
        best_coords_d = run_coords_d;
        best_count_d  = run_cnt_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      run_idx_q     <= '0;
      run_best_q    <= '0;
      run_second_q  <= '0;
      run_cnt_q     <= '0;
      run_coords_q  <= '0;
      best_valid_q  <= 1'b0;
      best_index_q  <= '0;
      best_cost_q   <= '0;
      second_cost_q <= '0;
      best_coords_q <= '0;
      best_count_q  <= '0;
      seq_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_idx_q     <= run_idx_d;
      run_best_q    <= run_best_d;
      run_second_q  <= run_second_d;
      run_cnt_q     <= run_cnt_d;
      run_coords_q  <= run_coords_d;
      best_valid_q  <= best_valid_d;
      best_index_q  <= best_index_d;
      best_cost_q   <= best_cost_d;
      second_cost_q <= second_cost_d;
      best_coords_q <= best_coords_d;
      best_count_q  <= best_count_d;
      seq_err_q     <= seq_err_d;
    end
  end

  assign bus.cost_valid  = t_valid;
  assign bus.cost        = t_cost;
  assign bus.cost_index  = t_index;
  assign bus.best_valid  = best_valid_q;
  assign bus.best_index  = best_index_q;
  assign bus.best_cost   = best_cost_q;
  assign bus.second_cost = second_cost_q;
  assign bus.best_coords = best_coords_q;
  assign bus.best_count  = best_count_q;
  assign bus.seq_err     = seq_err_q;

endmodule

// File: tb/tb_hamming_cost_wta.sv
// Scoreboard bench for hamming_cost_wta: one default instance (256/4) and one
// 120/6 instance share a stimulus stream; a reference model pushes expected
// costs, group results and framing errors, and a negedge monitor pops them.
module tb_hamming_cost_wta;

  typedef struct {
    int cyc;
    int cost;
    int idx;
  } cost_exp_t;

  typedef struct {
    int cyc;
    int idx;
    int cost;
    int second;
    int coords;
    int count;
  } best_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int lat [2]     = '{8, 7};
  int allones [2] = '{511, 127};

  cost_exp_t cq [2][$];
  best_exp_t bq [2][$];
  int        sq [2][$];

  bit open [2];
  int gcost [2][$];
  int gidx [2][$];
  int gcoord [2];

  int last_cost [2], last_cidx [2], last_bidx [2], last_bcost [2];
  int last_sec [2], last_bco [2], last_bcnt [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hamming_cost_wta_if #(.BLK_SIZE(256), .COORD_W(16), .IDX_W(16), .CNT_W(8)) bus0 ();
  hamming_cost_wta_if #(.BLK_SIZE(120), .COORD_W(16), .IDX_W(16), .CNT_W(8)) bus1 ();

  hamming_cost_wta #(.BLK_SIZE(256), .LUT_BITS(4), .COORD_W(16), .IDX_W(16), .CNT_W(8))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  hamming_cost_wta #(.BLK_SIZE(120), .LUT_BITS(6), .COORD_W(16), .IDX_W(16), .CNT_W(8))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  function automatic void chk(int d, string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL dut%0d %s actual=%0d expected=%0d (cycle %0d)", d, nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [255:0] ones(int n);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [255:0] rvec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // Group result from the whole candidate list: first minimum wins, runner-up
  // is the minimum over everyone else.
  function automatic void close_group(int d);
    best_exp_t be;
    int w, sec, n;
    n = gcost[d].size();
    w = 0;
    for (int i = 1; i < n; i++) if (gcost[d][i] < gcost[d][w]) w = i;
    sec = allones[d];
    for (int i = 0; i < n; i++) if (i != w && gcost[d][i] < sec) sec = gcost[d][i];
    be.cyc    = cyc + lat[d] + 1;
    be.idx    = gidx[d][w];
    be.cost   = gcost[d][w];
    be.second = sec;
    be.coords = gcoord[d];
    be.count  = (n > 255) ? 255 : n;
    bq[d].push_back(be);
  endfunction

  function automatic void model(int d, bit f, bit l, int c, int idx, int coords);
    cost_exp_t ce;
    ce.cyc  = cyc + lat[d];
    ce.cost = c;
    ce.idx  = idx;
    cq[d].push_back(ce);
    if (f) begin
      if (open[d]) sq[d].push_back(cyc + lat[d] + 1);
      open[d] = 1'b1;
      gcost[d].delete();
      gidx[d].delete();
      gcoord[d] = coords;
    end else if (!open[d]) begin
      sq[d].push_back(cyc + lat[d] + 1);
    end
    if (open[d]) begin
      gcost[d].push_back(c);
      gidx[d].push_back(idx);
    end
    if (l && open[d]) begin
      close_group(d);
      open[d] = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      cq[d].delete();
      bq[d].delete();
      sq[d].delete();
      open[d] = 1'b0;
      last_cost[d] = 0; last_cidx[d] = 0; last_bidx[d] = 0; last_bcost[d] = 0;
      last_sec[d] = 0;  last_bco[d] = 0;  last_bcnt[d] = 0;
    end
  endfunction

  task automatic beat(bit f, bit l, logic [255:0] a, logic [255:0] b, int idx, int coords);
    logic [255:0] m;
    @(posedge clk); #1;
    bus0.in_valid = 1'b1; bus0.in_first = f; bus0.in_last = l;
    bus0.left = a; bus0.right = b;
    bus0.in_index = 16'(idx); bus0.in_coords = 16'(coords);
    bus1.in_valid = 1'b1; bus1.in_first = f; bus1.in_last = l;
    bus1.left = a[119:0]; bus1.right = b[119:0];
    bus1.in_index = 16'(idx); bus1.in_coords = 16'(coords);
    m = a ^ b;
    model(0, f, l, $countones(m), idx, coords);
    model(1, f, l, $countones(m[119:0]), idx, coords);
  endtask

  // Idle cycles carry random framing bits that must be ignored.
  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus0.in_valid = 1'b0; bus0.in_first = 1'($urandom()); bus0.in_last = 1'($urandom());
      bus1.in_valid = 1'b0; bus1.in_first = 1'($urandom()); bus1.in_last = 1'($urandom());
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1; bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic group(int n, int idx0, int coords, bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd && $urandom_range(0, 3) != 0) beat(i == 0, i == n - 1, rvec(), rvec(), idx0 + i, coords);
      else beat(i == 0, i == n - 1, ones($urandom_range(0, 12)), '0, idx0 + i, coords);
    end
  endtask

  task automatic mon(int d, bit cv, int c, int ci, bit bv, int bi, int bc, int sc,
                     int bco, int bn, bit se);
    cost_exp_t ce;
    best_exp_t be;
    int s;
    if (cv) begin
      if (cq[d].size() == 0) chk(d, "cost_unexpected", 1, 0);
      else begin
        ce = cq[d].pop_front();
        chk(d, "cost_cycle", cyc, ce.cyc);
        chk(d, "cost", c, ce.cost);
        chk(d, "cost_index", ci, ce.idx);
        last_cost[d] = ce.cost; last_cidx[d] = ce.idx;
      end
    end else begin
      chk(d, "cost_hold", c, last_cost[d]);
      chk(d, "cost_index_hold", ci, last_cidx[d]);
    end
    if (bv) begin
      if (bq[d].size() == 0) chk(d, "best_unexpected", 1, 0);
      else begin
        be = bq[d].pop_front();
        chk(d, "best_cycle", cyc, be.cyc);
        chk(d, "best_index", bi, be.idx);
        chk(d, "best_cost", bc, be.cost);
        chk(d, "second_cost", sc, be.second);
        chk(d, "best_coords", bco, be.coords);
        chk(d, "best_count", bn, be.count);
        last_bidx[d] = be.idx; last_bcost[d] = be.cost; last_sec[d] = be.second;
        last_bco[d] = be.coords; last_bcnt[d] = be.count;
      end
    end else begin
      chk(d, "best_hold", bc, last_bcost[d]);
      chk(d, "second_hold", sc, last_sec[d]);
      chk(d, "best_index_hold", bi, last_bidx[d]);
      chk(d, "best_coords_hold", bco, last_bco[d]);
      chk(d, "best_count_hold", bn, last_bcnt[d]);
    end
    if (se) begin
      if (sq[d].size() == 0) chk(d, "seq_err_unexpected", 1, 0);
      else begin
        s = sq[d].pop_front();
        chk(d, "seq_err_cycle", cyc, s);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, bus0.cost_valid, int'(bus0.cost), int'(bus0.cost_index), bus0.best_valid,
          int'(bus0.best_index), int'(bus0.best_cost), int'(bus0.second_cost),
          int'(bus0.best_coords), int'(bus0.best_count), bus0.seq_err);
      mon(1, bus1.cost_valid, int'(bus1.cost), int'(bus1.cost_index), bus1.best_valid,
          int'(bus1.best_index), int'(bus1.best_cost), int'(bus1.second_cost),
          int'(bus1.best_coords), int'(bus1.best_count), bus1.seq_err);
    end
  end

  initial begin
    bus0.in_valid = 1'b0; bus0.in_first = 1'b0; bus0.in_last = 1'b0;
    bus0.left = '0; bus0.right = '0; bus0.in_index = '0; bus0.in_coords = '0;
    bus1.in_valid = 1'b0; bus1.in_first = 1'b0; bus1.in_last = 1'b0;
    bus1.left = '0; bus1.right = '0; bus1.in_index = '0; bus1.in_coords = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk(0, "rst_cost_valid", int'(bus0.cost_valid), 0);
    chk(0, "rst_best_valid", int'(bus0.best_valid), 0);
    chk(0, "rst_seq_err", int'(bus0.seq_err), 0);
    chk(0, "rst_cost", int'(bus0.cost), 0);
    chk(0, "rst_second_cost", int'(bus0.second_cost), 0);
    chk(1, "rst_cost_valid", int'(bus1.cost_valid), 0);
    chk(1, "rst_best_count", int'(bus1.best_count), 0);
    mon_en = 1'b1;

    // Single-candidate group: all-ones vs all-zeros.
    beat(1'b1, 1'b1, ~256'd0, '0, 5, 16'h0a0b);
    idle(12);

    // Costs 10,3,3,7: tie keeps index 1, runner-up 3.
    beat(1'b1, 1'b0, ones(10), '0, 0, 16'h0101);
    beat(1'b0, 1'b0, ones(3),  '0, 1, 16'h0101);
    beat(1'b0, 1'b0, '0, ones(3), 2, 16'h0101);
    beat(1'b0, 1'b1, ones(7),  '0, 3, 16'h0101);
    idle(12);

    // Back-to-back groups with distinct coordinates.
    group(4, 10, 16'h1111, 1'b1);
    group(4, 20, 16'h2222, 1'b1);
    idle(12);

    // first, x, first, y, last: first group abandoned.
    beat(1'b1, 1'b0, rvec(), rvec(), 30, 16'h3333);
    beat(1'b0, 1'b0, rvec(), rvec(), 31, 16'h3333);
    beat(1'b1, 1'b0, rvec(), rvec(), 32, 16'h4444);
    beat(1'b0, 1'b0, rvec(), rvec(), 33, 16'h4444);
    beat(1'b0, 1'b1, rvec(), rvec(), 34, 16'h4444);
    idle(12);

    // Stray non-first beat while idle.
    beat(1'b0, 1'b1, rvec(), rvec(), 40, 16'h5555);
    idle(12);

    // Reset mid-group, then a fresh group.
    beat(1'b1, 1'b0, rvec(), rvec(), 50, 16'h6666);
    beat(1'b0, 1'b0, rvec(), rvec(), 51, 16'h6666);
    pulse_reset();
    group(3, 60, 16'h7777, 1'b1);
    idle(12);

    // Randomized groups with occasional framing violations.
    for (int g = 0; g < 40; g++) begin
      int e;
      e = $urandom_range(0, 9);
      if (e == 0) beat(1'b0, 1'($urandom()), rvec(), rvec(), 16'($urandom()), 16'($urandom()));
      else if (e == 1) begin
        beat(1'b1, 1'b0, rvec(), rvec(), 16'($urandom()), 16'($urandom()));
        beat(1'b0, 1'b0, rvec(), rvec(), 16'($urandom()), 16'($urandom()));
      end
      group($urandom_range(1, 6), $urandom_range(0, 60000), $urandom_range(0, 65535), 1'b1);
      idle($urandom_range(0, 2));
    end
    idle(12);

    // Long group: candidate count saturates.
    group(300, 100, 16'h8888, 1'b1);
    idle(20);

    for (int d = 0; d < 2; d++) begin
      chk(d, "cost_queue_drained", cq[d].size(), 0);
      chk(d, "best_queue_drained", bq[d].size(), 0);
      chk(d, "seq_queue_drained", sq[d].size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
